// File: rtl/game_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// game_ctrl_fsm
//
// Top-level game-flow controller for the STG core. It sequences the boot,
// title, play, hit-invulnerability, bomb, stage-clear, success and game-over
// phases. It tracks lives, bombs and the current stage, and gates the
// playfield through game_en, game_reset and invuln.
//
// Optional feature macro: GAME_CTRL_PAUSE_EN
//   defined   : pause edge detector and PAUSE state are built in; PLAY honours
//               a pause edge, and a pause or enter edge resumes play.
//   undefined : the pause input is ignored and PAUSE (code 3) is unreachable.
//
// Ports
//   clk         in   system clock
//   hard_reset  in   asynchronous, active-high reset
//   enter       in   level; rising edge starts, advances or restarts
//   bomb        in   level; rising edge uses a bomb
//   pause       in   level; rising edge toggles pause (feature builds only)
//   collision   in   player was hit this cycle
//   die         in   boss was destroyed this cycle
//   num_life    out  remaining lives
//   num_bomb    out  remaining bombs
//   stage       out  current stage index
//   game_state  out  state code (exposed for debug and checkers)
//   game_en     out  playfield logic advances (PLAY, HIT, BOMB)
//   game_reset  out  one-cycle playfield reset pulse
//   invuln      out  player invulnerable (HIT, BOMB)
//
// Handshake note: this block has no valid/ready interfaces. Inputs are plain
// levels or per-cycle strobes sampled on every rising clk edge; every output
// is a register that reflects the state entered on that same edge.
// -----------------------------------------------------------------------------
module game_ctrl_fsm #(
  parameter int LIFE_W     = 4,
  parameter int LIFE_INIT  = 3,
  parameter int BOMB_INIT  = 3,
  parameter int NUM_STAGES = 3,
  parameter int TIMER_W    = 32,
  parameter int BOOT_TICKS = 20000000,
  parameter int HIT_TICKS  = 20000000,
  parameter int BOMB_TICKS = 40000000
) (
  input  logic                clk,
  input  logic                hard_reset,
  input  logic                enter,
  input  logic                bomb,
  input  logic                pause,
  input  logic                collision,
  input  logic                die,
  output logic [LIFE_W-1:0]   num_life,
  output logic [LIFE_W-1:0]   num_bomb,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] stage,
  output logic [3:0]          game_state,
  output logic                game_en,
  output logic                game_reset,
  output logic                invuln
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [SW-1:0]      LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [TIMER_W-1:0] BOOT_LOAD  = TIMER_W'(BOOT_TICKS);
  localparam logic [TIMER_W-1:0] HIT_LOAD   = TIMER_W'(HIT_TICKS);
  localparam logic [TIMER_W-1:0] BOMB_LOAD  = TIMER_W'(BOMB_TICKS);
  localparam logic [LIFE_W-1:0]  LIFE_LOAD  = LIFE_W'(LIFE_INIT);
  localparam logic [LIFE_W-1:0]  BOMB_LOAD_N = LIFE_W'(BOMB_INIT);

  typedef enum logic [3:0] {
    S_INIT        = 4'd0,
    S_START       = 4'd1,
    S_PLAY        = 4'd2,
    S_PAUSE       = 4'd3,
    S_BOMB        = 4'd6,
    S_STAGE_CLEAR = 4'd7,
    S_SUCCESS     = 4'd8,
    S_GAMEOVER    = 4'd9,
    S_HIT         = 4'd10
  } state_t;

  state_t             state, state_nxt, die_target;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [LIFE_W-1:0]  life_nxt, bomb_nxt;
  logic [SW-1:0]      stage_nxt;
  logic               greset_nxt;

  // Rising-edge detectors on the level inputs
  logic enter_q, bomb_q;
  logic enter_edge, bomb_edge;
  assign enter_edge = enter & ~enter_q;
  assign bomb_edge  = bomb & ~bomb_q;

`ifdef GAME_CTRL_PAUSE_EN
  logic pause_q;
  logic pause_edge;
  assign pause_edge = pause & ~pause_q;

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) pause_q <= 1'b0;
    else            pause_q <= pause;
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
`endif

  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      enter_q <= 1'b0;
      bomb_q  <= 1'b0;
    end else begin
      enter_q <= enter;
      bomb_q  <= bomb;
    end
  end

  // A boss kill ends the stage; on the last stage it ends the game.
  assign die_target = (stage < LAST_STAGE) ? S_STAGE_CLEAR : S_SUCCESS;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    life_nxt   = num_life;
    bomb_nxt   = num_bomb;
    stage_nxt  = stage;
    greset_nxt = 1'b0;
    case (state)
      S_INIT: begin
        if (timer == '0) state_nxt = S_START;
        else             timer_nxt = timer - 1'b1;
      end
      S_START: begin
        if (enter_edge) begin
          greset_nxt = 1'b1;
          stage_nxt  = '0;
          state_nxt  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (die) begin
          state_nxt = die_target;
        end else if (collision) begin
          // Out of lives: the count holds at zero rather than wrapping.
          if (num_life == '0) begin
            state_nxt = S_GAMEOVER;
          end else begin
            life_nxt  = num_life - 1'b1;
            timer_nxt = HIT_LOAD;
            state_nxt = S_HIT;
          end
        end else if (bomb_edge && (num_bomb != '0)) begin
          bomb_nxt  = num_bomb - 1'b1;
          timer_nxt = BOMB_LOAD;
          state_nxt = S_BOMB;
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (pause_edge) begin
          state_nxt = S_PAUSE;
        end
`endif
      end
      S_HIT: begin
        if (die) begin
          state_nxt = die_target;
        end else if (bomb_edge && (num_bomb != '0)) begin
          bomb_nxt  = num_bomb - 1'b1;
          timer_nxt = BOMB_LOAD;
          state_nxt = S_BOMB;
        end else if (timer == '0) begin
          state_nxt = S_PLAY;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_BOMB: begin
        if (die)                 state_nxt = die_target;
        else if (timer == '0)    state_nxt = S_PLAY;
        else                     timer_nxt = timer - 1'b1;
      end
`ifdef GAME_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (pause_edge || enter_edge) state_nxt = S_PLAY;
      end
`endif
      S_STAGE_CLEAR: begin
        if (enter_edge) begin
          stage_nxt  = stage + 1'b1;
          greset_nxt = 1'b1;
          state_nxt  = S_PLAY;
        end
      end
      S_SUCCESS, S_GAMEOVER: begin
        if (enter_edge) begin
          life_nxt   = LIFE_LOAD;
          bomb_nxt   = BOMB_LOAD_N;
          stage_nxt  = '0;
          greset_nxt = 1'b1;
          timer_nxt  = BOOT_LOAD;
          state_nxt  = S_INIT;
        end
      end
      default: begin
        // Unused codes recover through a fresh boot.
        timer_nxt = BOOT_LOAD;
        state_nxt = S_INIT;
      end
    endcase
  end

  // game_en / invuln are registered from the next state so they line up
  // with game_state on the same edge.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state      <= S_INIT;
      timer      <= BOOT_LOAD;
      num_life   <= LIFE_LOAD;
      num_bomb   <= BOMB_LOAD_N;
      stage      <= '0;
      game_en    <= 1'b0;
      game_reset <= 1'b0;
      invuln     <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      num_life   <= life_nxt;
      num_bomb   <= bomb_nxt;
      stage      <= stage_nxt;
      game_en    <= (state_nxt == S_PLAY) || (state_nxt == S_HIT) ||
                    (state_nxt == S_BOMB);
      game_reset <= greset_nxt;
      invuln     <= (state_nxt == S_HIT) || (state_nxt == S_BOMB);
    end
  end

  assign game_state = state;

endmodule

// File: doc/game_ctrl_fsm.md
# game_ctrl_fsm

Parametrised top-level game-flow controller for the STG core. It sequences boot, title, play, hit-invulnerability, bomb, stage-clear, success and game-over phases. It tracks lives, bombs and the current stage, and gates the playfield logic through `game_en`, `game_reset` and `invuln`. It supersedes the fixed-count controller by adding parametrised counters and timers, multi-stage progression, an underflow-safe life count, and an optional pause.

## Interface
- `LIFE_W`, 4: width of the life and bomb counters.
- `LIFE_INIT`, 3: lives loaded at boot and on restart.
- `BOMB_INIT`, 3: bombs loaded at boot and on restart.
- `NUM_STAGES`, 3: number of stages; the last stage is `NUM_STAGES-1`; must be ≥1.
- `TIMER_W`, 32: timeout counter width.
- `BOOT_TICKS`, 20000000: INIT dwell.
- `HIT_TICKS`, 20000000: HIT (invulnerable) dwell.
- `BOMB_TICKS`, 40000000: BOMB dwell.
- `clk` in 1: system clock.
- `hard_reset` in 1: reset, asynchronous, active-high. Clock is `clk`.
- `enter` in 1: level input; rising edge used.
- `bomb` in 1: level input; rising edge used.
- `pause` in 1: level input; rising edge used. Only active with the pause feature compiled in.
- `collision` in 1: player hit this cycle.
- `die` in 1: boss destroyed this cycle.
- `num_life` out `LIFE_W`: remaining lives.
- `num_bomb` out `LIFE_W`: remaining bombs.
- `stage` out `$clog2(NUM_STAGES)` (min 1): current stage index.
- `game_state` out 4: state code.
- `game_en` out 1: playfield logic advances.
- `game_reset` out 1: one-cycle playfield reset pulse.
- `invuln` out 1: high in HIT and BOMB.

## Operation
- State codes: INIT=0, START=1, PLAY=2, PAUSE=3, BOMB=6, STAGE_CLEAR=7, SUCCESS=8, GAMEOVER=9, HIT=10.
- Edge detection: `x_edge = x & ~x_q`, with `x_q` registered each cycle and reset to 0.
- Timer: loading N makes the state last N+1 cycles. The timer decrements while >0; the transition happens in the cycle it reads 0.
- INIT: count down `BOOT_TICKS`, then go to START.
- START: on `enter_edge`, pulse `game_reset`, set stage=0, go to PLAY.
- PLAY: events are checked in this priority order.
  - `die`:
    - if stage < `NUM_STAGES-1`, go to STAGE_CLEAR;
    - otherwise go to SUCCESS.
  - `collision`:
    - if `num_life`==0, go to GAMEOVER; `num_life` holds at 0 and never wraps;
    - otherwise `num_life`-1, load `HIT_TICKS`, go to HIT.
  - `bomb_edge` with `num_bomb`>0: `num_bomb`-1, load `BOMB_TICKS`, go to BOMB. With `num_bomb`==0 the edge is ignored.
  - `pause_edge`: go to PAUSE.
- HIT:
  - `die` wins and follows the PLAY `die` rules.
  - Otherwise `bomb_edge` with `num_bomb`>0 gives `num_bomb`-1, loads `BOMB_TICKS`, and goes to BOMB.
  - Otherwise the timer expiring returns to PLAY.
  - `collision` is ignored.
- BOMB:
  - `die` follows the PLAY `die` rules.
  - Timer expiry returns to PLAY.
  - `collision`, `bomb` and `pause` are ignored.
- PAUSE: `game_en`=0. `pause_edge` or `enter_edge` returns to PLAY. Counters and the timer are frozen.
- STAGE_CLEAR: `game_en`=0. On `enter_edge`: stage+1, pulse `game_reset`, go to PLAY. Lives and bombs carry over.
- SUCCESS / GAMEOVER: `game_en`=0. On `enter_edge`: reload `LIFE_INIT` and `BOMB_INIT`, stage=0, pulse `game_reset`, load `BOOT_TICKS`, go to INIT.
- `game_en`: 1 in PLAY, HIT and BOMB; 0 elsewhere.

## Timing
- All outputs are registered; each output reflects the state entered on the same clock edge.
- `game_reset` is high exactly one cycle: the cycle after the triggering `enter` edge is sampled.
- Event-to-state latency is 1 cycle.
- Reset values: `game_state`=INIT, timer=`BOOT_TICKS`, `num_life`=`LIFE_INIT`, `num_bomb`=`BOMB_INIT`, stage=0, `game_en`=0, `game_reset`=0, `invuln`=0, edge registers 0.
- Reset asserted mid-game forces the reset values immediately (asynchronously). No `game_reset` pulse is emitted.
- Level inputs held high produce one edge only.

## Configuration
- Macro: `GAME_CTRL_PAUSE_EN`.
- Defined: the `pause` edge detector and the PAUSE state are built in, and PLAY honours `pause_edge`.
- Undefined: the `pause` input is ignored (no logic), PAUSE is unreachable, and code 3 never appears on `game_state`.

## Test plan
Parameters for all scenarios: `BOOT_TICKS`=4, `HIT_TICKS`=3, `BOMB_TICKS`=5, `LIFE_INIT`=1, `BOMB_INIT`=1, `NUM_STAGES`=2.
- Boot: release reset, hold `enter`=0 → `game_state`=0 for 5 cycles, then 1; `game_en`=0 throughout.
- Start and hit: `enter` pulse in START → `game_reset` high 1 cycle, state 2, `game_en`=1. Then `collision` → state 10, `num_life`=0, `invuln`=1 for 4 cycles, then state 2. Second `collision` → state 9, `num_life` stays 0.
- Bomb: `bomb` held high for 10 cycles in PLAY → exactly one bomb used, `num_bomb`=0, state 6 for 6 cycles, back to 2. A further `bomb` edge is ignored.
- Stages: `die` in stage 0 → state 7. `enter` → stage=1, `game_reset` pulse, state 2. `die` → state 8. `enter` → `num_life`=1, `num_bomb`=1, stage=0, state 0.
- Simultaneous: `die` and `collision` in the same PLAY cycle → state 7, `num_life` unchanged.
- Pause, with `GAME_CTRL_PAUSE_EN` defined: `pause` edge in HIT → ignored. `pause` edge in PLAY → state 3, `game_en`=0, counters frozen; a second edge returns to state 2. Without the macro, state 3 is never observed.
